// File: rtl/jtcop_hostarb_if.sv
// Host-side bus of the layer-chip arbiter: one instance per host (CPU, MCU).
// The host drives the request fields; the arbiter returns ack and read data.
interface jtcop_hostarb_if #(
    parameter int SW = 2,
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          req;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic [1:0]    dsn;
    logic          rnw;
    logic          ack;
    logic [DW-1:0] din;

    modport master (output req, sel, addr, dout, dsn, rnw, input  ack, din);
    modport slave  (input  req, sel, addr, dout, dsn, rnw, output ack, din);
endinterface

// File: rtl/jtcop_hostarb.sv
// Round-robin arbiter sharing NLAYER layer chips between a CPU and an MCU host.
// Each access holds the layer port ACC_CYC cycles, then pulses the host's ack.
module jtcop_hostarb #(
    parameter int NLAYER  = 3,
    parameter int AW      = 12,
    parameter int DW      = 16,
    parameter int ACC_CYC = 2,
    localparam int SW     = (NLAYER > 1) ? $clog2(NLAYER) : 1
) (
    input  logic               clk,
    input  logic               rst,
    jtcop_hostarb_if.slave     cpu,
    jtcop_hostarb_if.slave     mcu,
    output logic [NLAYER-1:0]  lyr_cs,
    output logic [AW-1:0]      lyr_addr,
    output logic [DW-1:0]      lyr_din,
    output logic [1:0]         lyr_dsn,
    output logic               lyr_rnw,
    input  logic [NLAYER*DW-1:0] lyr_dout,
    input  logic [7:0]         st_addr,
    input  logic [NLAYER*8-1:0] st_in,
    output logic [7:0]         st_dout
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACC_CYC - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic          prio_mcu;   // MCU wins a tie when the CPU was served last
    logic          g_mcu;
    logic [SW-1:0] g_sel;

    logic               cpu_go, mcu_go;
    logic [SW-1:0]      h_sel;
    logic [AW-1:0]      h_addr;
    logic [DW-1:0]      h_dout;
    logic [1:0]         h_dsn;
    logic               h_rnw;
    logic [NLAYER-1:0]  h_cs;
    logic [DW-1:0]      rd_data;
    logic [7:0]         st_next;
    logic [4:0]         st_idx;

    wire unused_st_bits = &{1'b0, st_addr[2:0]};

    assign st_idx = st_addr[7:3];

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it holding its old value (no latch).
    always_comb begin
        cpu_go = cpu.req && (!mcu.req || !prio_mcu);
        mcu_go = mcu.req && !cpu_go;
        h_sel  = mcu_go ? mcu.sel  : cpu.sel;
        h_addr = mcu_go ? mcu.addr : cpu.addr;
        h_dout = mcu_go ? mcu.dout : cpu.dout;
        h_dsn  = mcu_go ? mcu.dsn  : cpu.dsn;
        h_rnw  = mcu_go ? mcu.rnw  : cpu.rnw;

        h_cs    = '0;
        rd_data = '1;
        st_next = 8'hFF;
        // Out-of-range selects match no k: no chip select, all-ones data.
        for (int k = 0; k < NLAYER; k++) begin
            h_cs[k] = (32'(h_sel) == k);
            if (32'(g_sel) == k)  rd_data = lyr_dout[k*DW +: DW];
            if (32'(st_idx) == k) st_next = st_in[k*8 +: 8];
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            prio_mcu <= 1'b0;
            g_mcu    <= 1'b0;
            g_sel    <= '0;
            lyr_cs   <= '0;
            lyr_addr <= '0;
            lyr_din  <= '0;
            lyr_dsn  <= 2'b11;
            lyr_rnw  <= 1'b1;
            cpu.ack  <= 1'b0;
            mcu.ack  <= 1'b0;
            cpu.din  <= '0;
            mcu.din  <= '0;
            st_dout  <= '0;
        end else begin
            st_dout <= st_next;
            case (state)
                IDLE: begin
                    if (cpu_go || mcu_go) begin
                        state    <= ACCESS;
                        cnt      <= CNT_INIT;
                        g_mcu    <= mcu_go;
                        prio_mcu <= cpu_go;
                        g_sel    <= h_sel;
                        lyr_cs   <= h_cs;
                        lyr_addr <= h_addr;
                        lyr_din  <= h_dout;
                        lyr_dsn  <= h_dsn;
                        lyr_rnw  <= h_rnw;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state   <= ACK;
                        lyr_cs  <= '0;
                        lyr_dsn <= 2'b11;
                        lyr_rnw <= 1'b1;
                        if (g_mcu) begin
                            mcu.ack <= 1'b1;
                            if (lyr_rnw) mcu.din <= rd_data;
                        end else begin
                            cpu.ack <= 1'b1;
                            if (lyr_rnw) cpu.din <= rd_data;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    state   <= IDLE;
                    cpu.ack <= 1'b0;
                    mcu.ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtcop_hostarb.sv
// Directed bench for jtcop_hostarb (NLAYER=3, ACC_CYC=2): reads, writes,
// round-robin ties, out-of-range select, reset mid-access and status port.
module tb_jtcop_hostarb;
    localparam int NLAYER = 3;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NLAYER-1:0]    lyr_cs;
    logic [AW-1:0]        lyr_addr;
    logic [DW-1:0]        lyr_din;
    logic [1:0]           lyr_dsn;
    logic                 lyr_rnw;
    logic [NLAYER*DW-1:0] lyr_dout;
    logic [7:0]           st_addr;
    logic [NLAYER*8-1:0]  st_in;
    logic [7:0]           st_dout;

    int n_cmp  = 0;
    int n_fail = 0;

    jtcop_hostarb_if #(.SW(SW), .AW(AW), .DW(DW)) cpu_if ();
    jtcop_hostarb_if #(.SW(SW), .AW(AW), .DW(DW)) mcu_if ();

    jtcop_hostarb #(.NLAYER(NLAYER), .AW(AW), .DW(DW), .ACC_CYC(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu      (cpu_if),
        .mcu      (mcu_if),
        .lyr_cs   (lyr_cs),
        .lyr_addr (lyr_addr),
        .lyr_din  (lyr_din),
        .lyr_dsn  (lyr_dsn),
        .lyr_rnw  (lyr_rnw),
        .lyr_dout (lyr_dout),
        .st_addr  (st_addr),
        .st_in    (st_in),
        .st_dout  (st_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just past it; inputs are changed here too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input logic req, input logic [SW-1:0] sel, input logic [AW-1:0] addr,
                           input logic [DW-1:0] dout, input logic [1:0] dsn, input logic rnw);
        cpu_if.req = req; cpu_if.sel = sel; cpu_if.addr = addr;
        cpu_if.dout = dout; cpu_if.dsn = dsn; cpu_if.rnw = rnw;
    endtask

    task automatic mcu_set(input logic req, input logic [SW-1:0] sel, input logic [AW-1:0] addr,
                           input logic [DW-1:0] dout, input logic [1:0] dsn, input logic rnw);
        mcu_if.req = req; mcu_if.sel = sel; mcu_if.addr = addr;
        mcu_if.dout = dout; mcu_if.dsn = dsn; mcu_if.rnw = rnw;
    endtask

    initial begin
        rst      = 1'b1;
        lyr_dout = {16'h2222, 16'hBEEF, 16'h1111};
        st_in    = {8'h33, 8'h5A, 8'h11};
        st_addr  = 8'h00;
        cpu_set(1'b0, 2'd0, 12'h000, 16'h0000, 2'b11, 1'b1);
        mcu_set(1'b0, 2'd0, 12'h000, 16'h0000, 2'b11, 1'b1);
        step();
        step();

        // Reset values
        check("rst_cs",      lyr_cs, 3'b000);
        check("rst_rnw",     lyr_rnw, 1'b1);
        check("rst_dsn",     lyr_dsn, 2'b11);
        check("rst_addr",    lyr_addr, 12'h000);
        check("rst_din",     lyr_din, 16'h0000);
        check("rst_cpu_ack", cpu_if.ack, 1'b0);
        check("rst_mcu_ack", mcu_if.ack, 1'b0);
        check("rst_cpu_din", cpu_if.din, 16'h0000);
        check("rst_mcu_din", mcu_if.din, 16'h0000);
        check("rst_st_dout", st_dout, 8'h00);
        rst = 1'b0;

        // CPU read layer 1; inputs change and req drops mid-access
        cpu_set(1'b1, 2'd1, 12'h123, 16'h0000, 2'b00, 1'b1);
        step();
        check("rd_c1_cs",   lyr_cs, 3'b010);
        check("rd_c1_addr", lyr_addr, 12'h123);
        check("rd_c1_rnw",  lyr_rnw, 1'b1);
        check("rd_c1_ack",  cpu_if.ack, 1'b0);
        cpu_set(1'b0, 2'd2, 12'h456, 16'h0000, 2'b11, 1'b0);
        step();
        check("rd_c2_cs",   lyr_cs, 3'b010);
        check("rd_c2_addr", lyr_addr, 12'h123);
        check("rd_c2_rnw",  lyr_rnw, 1'b1);
        step();
        check("rd_c3_cs",   lyr_cs, 3'b000);
        check("rd_c3_ack",  cpu_if.ack, 1'b1);
        check("rd_c3_din",  cpu_if.din, 16'hBEEF);
        check("rd_c3_mack", mcu_if.ack, 1'b0);
        step();
        check("rd_idle_ack", cpu_if.ack, 1'b0);
        check("rd_idle_din", cpu_if.din, 16'hBEEF);

        // Simultaneous requests right after reset: CPU, then MCU, then CPU
        rst = 1'b1;
        step();
        rst = 1'b0;
        cpu_set(1'b1, 2'd0, 12'h001, 16'h0000, 2'b00, 1'b1);
        mcu_set(1'b1, 2'd2, 12'h002, 16'h0000, 2'b00, 1'b1);
        step();
        check("rr1_cs", lyr_cs, 3'b001);
        step();
        step();
        check("rr1_cack", cpu_if.ack, 1'b1);
        check("rr1_mack", mcu_if.ack, 1'b0);
        check("rr1_din",  cpu_if.din, 16'h1111);
        cpu_if.req = 1'b0;
        step();
        check("rr_idle_cack", cpu_if.ack, 1'b0);
        check("rr_idle_mack", mcu_if.ack, 1'b0);
        step();
        check("rr2_cs",   lyr_cs, 3'b100);
        check("rr2_addr", lyr_addr, 12'h002);
        step();
        step();
        check("rr2_mack", mcu_if.ack, 1'b1);
        check("rr2_cack", cpu_if.ack, 1'b0);
        check("rr2_din",  mcu_if.din, 16'h2222);
        mcu_if.req = 1'b0;
        step();
        cpu_if.req = 1'b1;
        mcu_if.req = 1'b1;
        step();
        check("rr3_cs", lyr_cs, 3'b001);
        step();
        step();
        check("rr3_cack", cpu_if.ack, 1'b1);
        check("rr3_mack", mcu_if.ack, 1'b0);
        cpu_if.req = 1'b0;
        mcu_if.req = 1'b0;
        step();

        // MCU write to layer 2: lyr_* driven, mcu_din untouched
        mcu_set(1'b1, 2'd2, 12'h0AA, 16'h00A5, 2'b10, 1'b0);
        step();
        check("wr_c1_cs",  lyr_cs, 3'b100);
        check("wr_c1_rnw", lyr_rnw, 1'b0);
        check("wr_c1_din", lyr_din, 16'h00A5);
        check("wr_c1_dsn", lyr_dsn, 2'b10);
        mcu_if.req = 1'b0;
        step();
        check("wr_c2_rnw", lyr_rnw, 1'b0);
        check("wr_c2_din", lyr_din, 16'h00A5);
        check("wr_c2_dsn", lyr_dsn, 2'b10);
        step();
        check("wr_ack",     mcu_if.ack, 1'b1);
        check("wr_mcu_din", mcu_if.din, 16'h2222);
        check("wr_end_rnw", lyr_rnw, 1'b1);
        check("wr_end_dsn", lyr_dsn, 2'b11);
        step();

        // CPU read of a non-existent layer
        cpu_set(1'b1, 2'd3, 12'h010, 16'h0000, 2'b00, 1'b1);
        step();
        check("oor_c1_cs", lyr_cs, 3'b000);
        cpu_if.req = 1'b0;
        step();
        check("oor_c2_cs", lyr_cs, 3'b000);
        step();
        check("oor_ack", cpu_if.ack, 1'b1);
        check("oor_din", cpu_if.din, 16'hFFFF);
        step();

        // Reset during the first ACCESS cycle aborts without ack
        cpu_set(1'b1, 2'd1, 12'h3C3, 16'h0000, 2'b00, 1'b1);
        step();
        check("abort_pre_cs", lyr_cs, 3'b010);
        rst = 1'b1;
        cpu_if.req = 1'b0;
        step();
        check("abort_cs",   lyr_cs, 3'b000);
        check("abort_ack",  cpu_if.ack, 1'b0);
        check("abort_addr", lyr_addr, 12'h000);
        check("abort_rnw",  lyr_rnw, 1'b1);
        check("abort_din",  cpu_if.din, 16'h0000);
        rst = 1'b0;
        step();
        step();
        check("abort_no_ack", cpu_if.ack, 1'b0);

        // Status readback
        st_addr = 8'h08;
        step();
        check("st_l1", st_dout, 8'h5A);
        st_addr = 8'h18;
        step();
        check("st_oor", st_dout, 8'hFF);
        st_addr = 8'h10;
        step();
        check("st_l2", st_dout, 8'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/jtcop_hostarb.md
JTCOP_HOSTARB -- requirements
Module: jtcop_hostarb

Interface
REQ-001 SHALL have parameter NLAYER, default 3, number of layer chips (1..8).
REQ-002 SHALL have parameter AW, default 12, host/layer word-address width.
REQ-003 SHALL have parameter DW, default 16, data width.
REQ-004 SHALL have parameter ACC_CYC, default 2, cycles the layer port is held per access (1..15).
REQ-005 SHALL derive SW = max(1, clog2(NLAYER)) as the layer-select width.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 cpu_req in 1; cpu_sel in SW; cpu_addr in AW; cpu_dout in DW; cpu_dsn in 2; cpu_rnw in 1: CPU host request, select, address, write data, byte strobes (active low), read/not-write.
REQ-009 cpu_ack  out  1  one-cycle access-done pulse; cpu_din  out  DW  CPU read data.
REQ-010 mcu_req, mcu_sel, mcu_addr, mcu_dout, mcu_dsn, mcu_rnw, mcu_ack, mcu_din: MCU host, same widths and meanings as the CPU host.
REQ-011 lyr_cs  out  NLAYER  one-hot layer chip select; lyr_addr out AW; lyr_din out DW; lyr_dsn out 2; lyr_rnw out 1.
REQ-012 lyr_dout  in  NLAYER*DW  read data, layer k at bits [k*DW +: DW].
REQ-013 st_addr in 8; st_in in NLAYER*8 (layer k status at [k*8 +: 8]); st_dout out 8 registered status.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, ACK; IDLE->ACCESS on grant, ACCESS->ACK after exactly ACC_CYC cycles, ACK->IDLE unconditionally.
REQ-015 Requests SHALL be sampled only in IDLE; one request alone is granted that cycle.
REQ-016 Simultaneous requests SHALL be resolved round-robin: host not granted last wins; after reset the CPU wins first.
REQ-017 On grant, the granted host's sel/addr/dout/dsn/rnw SHALL be registered and driven on lyr_* for all ACCESS cycles, unaffected by later host input changes.
REQ-018 lyr_cs SHALL have only bit sel set during ACCESS and be all-zero in IDLE and ACK.
REQ-019 lyr_rnw SHALL be 1 and lyr_dsn 2'b11 outside ACCESS.
REQ-020 For reads, lyr_dout of the selected layer SHALL be captured on the last ACCESS cycle into the granted host's din, visible in the ACK cycle and held until that host's next read completes.
REQ-021 Writes SHALL not alter either din.
REQ-022 The granted host's ack SHALL be high only in the ACK cycle; the other host's ack stays 0.
REQ-023 Total latency grant-cycle to ack SHALL be ACC_CYC+1 cycles.
REQ-024 sel >= NLAYER SHALL assert no lyr_cs, still complete with ack, and return all-ones read data.
REQ-025 Requester deasserting req mid-access SHALL not abort; the access completes and ack still pulses.
REQ-026 Hosts SHALL drop req the cycle after ack; req still high in the following IDLE is a new access.
REQ-027 st_dout SHALL register st_in layer st_addr[7:3] every cycle (latency 1); index >= NLAYER yields 8'hFF.

Reset
REQ-028 rst SHALL force, on the next edge, state IDLE, lyr_cs=0, lyr_rnw=1, lyr_dsn=2'b11, lyr_addr=0, lyr_din=0, both acks 0, both din 0, st_dout 0, round-robin pointer to CPU.
REQ-029 rst during ACCESS SHALL abort without ack; lyr_cs drops on that edge.

Verification
REQ-030 NLAYER=3, ACC_CYC=2: CPU read sel=1 addr=0x123, layer1 dout=0xBEEF -> lyr_cs=3'b010 two cycles, cpu_ack at cycle 3, cpu_din=0xBEEF.
REQ-031 Both hosts request after reset -> CPU served first, then MCU; next simultaneous pair -> CPU (alternation), acks never overlap.
REQ-032 MCU write sel=2 dout=0x00A5 dsn=2'b10 -> lyr_rnw=0, lyr_din=0x00A5, lyr_dsn=2'b10 two cycles; mcu_din unchanged.
REQ-033 CPU read sel=3 (NLAYER=3) -> lyr_cs stays 0, cpu_ack pulses, cpu_din=0xFFFF.
REQ-034 rst asserted in first ACCESS cycle -> lyr_cs=0 next edge, no ack, reset values everywhere.
REQ-035 st_addr=0x08 with st_in layer1=0x5A -> st_dout=0x5A one cycle later; st_addr=0x18 -> 0xFF.
